apb_arbiter: RTL and testbench
==============================

Name: apb_arbiter

Overview:
- 4-requester arbiter that consumes the configuration outputs of the APB slave register block: APB_BYPASS, APB_REQ[3:0] and APB_ARB_TYPE[2:0].
- Combines hardware requests with software-injected requests and selects the arbitration policy from the programmed type.
- Drives a registered one-hot grant to the clients.
- Sits directly downstream of the APB slave, in the same PCLK domain.

Parameters:
- MAX_HOLD, 8: maximum number of cycles a round-robin grant is held while other requests are pending. Legal range 1..15.
- CNT_W, 4: width of the hold counter. Must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- PCLK  input  1  clock; all logic is on the rising edge.
- PRESETn  input  1  reset, synchronous, active-low.
- APB_BYPASS  input  1  bypass enable from the APB slave.
- APB_REQ  input  4  software-injected requests from the APB slave.
- APB_ARB_TYPE  input  3  arbitration policy select from the APB slave.
- REQ  input  4  hardware requests; bit i belongs to client i. Level-sensitive, held until served.
- GNT  output  4  registered grant. One-hot or zero except in BYPASS.
- GNT_VALID  output  1  registered; 1 when GNT is nonzero.
- GNT_ID  output  2  registered; index of the granted client. Meaningful only when GNT_VALID=1 outside BYPASS.

Behaviour:
- Reset: PRESETn sampled low at a PCLK edge gives state=IDLE, GNT=0, GNT_VALID=0, GNT_ID=0, hold_cnt=0, rr_last=3. Reset overrides every other event, including mid-grant.
- Effective request: ereq = REQ | APB_REQ.
- Policy decode:
  - 0: fixed priority, client 0 highest.
  - 1: round robin, search starting at rr_last+1 mod 4.
  - 2: reverse fixed priority, client 3 highest.
  - 3..7: reserved, behave as 0.
- Policy is sampled only at an arbitration decision. A change while a grant is held does not disturb that grant.
- Latency: request visible at edge N gives grant visible after edge N+1. Grants are never combinational.
- FSM states are IDLE, BUSY and BYPASS, evaluated at each edge in priority order.
- Any state with APB_BYPASS=1:
  - Next state is BYPASS, GNT<=REQ (raw, not one-hot), GNT_VALID<=|REQ.
  - GNT_ID unchanged, hold_cnt<=0.
- BYPASS with APB_BYPASS=0:
  - Next state is IDLE with GNT<=0. This gives a mandatory one-cycle zero-grant bubble.
- IDLE:
  - If ereq!=0: go to BUSY, GNT<=onehot(pick), GNT_ID<=pick, hold_cnt<=1. If policy is 1, rr_last<=pick.
  - Otherwise stay in IDLE with outputs 0.
- BUSY, holder h:
  - If ereq[h]=0 (release): re-arbitrate over ereq in the same edge (no bubble). If the result is nonzero, grant the new pick with hold_cnt<=1. If the result is zero, go to IDLE with GNT<=0.
  - Else if policy is 1, hold_cnt==MAX_HOLD and (ereq & ~onehot(h))!=0: preempt. Pick from ereq excluding h, grant it, hold_cnt<=1, rr_last<=pick.
  - Else keep the grant and saturate hold_cnt at MAX_HOLD. Fixed-priority policies never preempt.
- rr_last updates only on grants issued under policy 1.
- Simultaneous release and new requests: handled by the same-edge re-arbitration described under BUSY.
- GNT_VALID always equals |GNT.

Decomposition:
- Package arb_pkg holds:
  - state encodings ST_IDLE=2'd0, ST_BUSY=2'd1, ST_BYPASS=2'd2;
  - policy codes ARB_FIXED=3'd0, ARB_RR=3'd1, ARB_REV=3'd2.
- Sub-module arb_pick: combinational.
  - Inputs: req[3:0], base[1:0], dir (ascending or descending).
  - Outputs: found and idx[1:0]. Searches from base with wrap-around.
  - Instantiated once. Policies map to base/dir as follows:
    - fixed: base=0, ascending;
    - reverse: base=3, descending;
    - round robin: base=rr_last+1, ascending, with the mask applied to req for preemption.

Test Plan:
- Reset mid-grant: grant REQ=4'b0010, then drive PRESETn low for 1 cycle. Expect GNT=0, GNT_VALID=0, GNT_ID=0 after that edge. Expect rr_last=3, shown by RR then granting client 0 first.
- Fixed priority: type=0, REQ=4'b1010 gives GNT=4'b0010 one edge later. Drop REQ[1] to give GNT=4'b1000 at the next edge, with no bubble. Type=2 with REQ=4'b0011 gives GNT=4'b0010.
- Software injection: REQ=0, APB_REQ=4'b0100 gives GNT=4'b0100 and GNT_ID=2. Clearing APB_REQ gives GNT=0 at the next edge.
- Round-robin preemption: type=1, MAX_HOLD=8, REQ=4'b1111 held.
  - Expect GNT sequence 0001 for 8 cycles, then 0010, 0100, 1000, then 0001, each held 8 cycles.
  - Type=0 with the same stimulus holds 0001 indefinitely.
- Bypass: APB_BYPASS=1 with REQ=4'b0101 gives GNT=4'b0101 and GNT_VALID=1. APB_BYPASS=0 gives GNT=0 for exactly 1 cycle, then GNT=4'b0001.
- Policy change mid-grant: holder 2 under type=0, switch to type=1 while REQ=4'b0111. Expect no preemption until holder 2 has held for MAX_HOLD cycles under type=1, then grant client 0 (search from rr_last=3).

Source files
------------

// File: rtl/arb_pkg.sv
// Shared encodings for the APB-configured 4-client arbiter.
// State and policy codes are plain localparams so older tools can consume them.
package arb_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_BUSY   = 2'd1;
    localparam logic [1:0] ST_BYPASS = 2'd2;

    localparam logic [2:0] ARB_FIXED = 3'd0;
    localparam logic [2:0] ARB_RR    = 3'd1;
    localparam logic [2:0] ARB_REV   = 3'd2;

    function automatic logic [3:0] onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational wrap-around search over four requests.
// Starts at base and walks up (dir=0) or down (dir=1); the first set bit wins.
module arb_pick
    import arb_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] base,
    input  logic       dir,
    output logic       found,
    output logic [1:0] idx
);

    logic [1:0] pos;

    // Walk from the farthest offset to the nearest so the closest hit is the last write.
    always_comb begin
        found = 1'b0;
        idx   = 2'd0;
        pos   = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            pos = dir ? (base - 2'(k)) : (base + 2'(k));
            if (req[pos]) begin
                found = 1'b1;
                idx   = pos;
            end
        end
    end

endmodule

// File: rtl/apb_arbiter.sv
// Four-requester arbiter driven by the APB slave configuration outputs.
// Registered one-hot grant with fixed, reverse-fixed and round-robin policies plus a raw bypass.
module apb_arbiter
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic       PCLK,
    input  logic       PRESETn,
    input  logic       APB_BYPASS,
    input  logic [3:0] APB_REQ,
    input  logic [2:0] APB_ARB_TYPE,
    input  logic [3:0] REQ,
    output logic [3:0] GNT,
    output logic       GNT_VALID,
    output logic [1:0] GNT_ID,
    output logic [1:0] dbg_state
);

    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);

    logic [1:0]       state;
    logic [CNT_W-1:0] hold_cnt;
    logic [1:0]       rr_last;

    logic [3:0] ereq;
    logic [2:0] policy;
    logic       holder_req;
    logic       preempt;
    logic [3:0] pick_req;
    logic [1:0] pick_base;
    logic       pick_dir;
    logic       pick_found;
    logic [1:0] pick_idx;

    assign dbg_state = state;
    assign ereq      = REQ | APB_REQ;

    // Reserved policy codes fall back to fixed priority.
    always_comb begin
        policy = ARB_FIXED;
        if (APB_ARB_TYPE == ARB_RR) begin
            policy = ARB_RR;
        end else if (APB_ARB_TYPE == ARB_REV) begin
            policy = ARB_REV;
        end
    end

    // While BUSY, GNT_ID always names the current holder.
    assign holder_req = ereq[GNT_ID];
    assign preempt    = (state == ST_BUSY) && holder_req && (policy == ARB_RR) &&
                        (hold_cnt == HOLD_MAX) && ((ereq & ~onehot(GNT_ID)) != 4'd0);
    assign pick_req   = preempt ? (ereq & ~onehot(GNT_ID)) : ereq;

    always_comb begin
        pick_base = 2'd0;
        pick_dir  = 1'b0;
        if (policy == ARB_RR) begin
            pick_base = rr_last + 2'd1;
        end else if (policy == ARB_REV) begin
            pick_base = 2'd3;
            pick_dir  = 1'b1;
        end
    end

    arb_pick u_pick (
        .req   (pick_req),
        .base  (pick_base),
        .dir   (pick_dir),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state     <= ST_IDLE;
            GNT       <= 4'd0;
            GNT_VALID <= 1'b0;
            GNT_ID    <= 2'd0;
            hold_cnt  <= '0;
            rr_last   <= 2'd3;
        end else if (APB_BYPASS) begin
            state     <= ST_BYPASS;
            GNT       <= REQ;
            GNT_VALID <= |REQ;
            hold_cnt  <= '0;
        end else begin
            case (state)
                ST_BYPASS: begin
                    // Leaving bypass always costs one empty grant cycle.
                    state     <= ST_IDLE;
                    GNT       <= 4'd0;
                    GNT_VALID <= 1'b0;
                end
                ST_IDLE: begin
                    if (pick_found) begin
                        state     <= ST_BUSY;
                        GNT       <= onehot(pick_idx);
                        GNT_VALID <= 1'b1;
                        GNT_ID    <= pick_idx;
                        hold_cnt  <= CNT_W'(1);
                        if (policy == ARB_RR) begin
                            rr_last <= pick_idx;
                        end
                    end else begin
                        GNT       <= 4'd0;
                        GNT_VALID <= 1'b0;
                        GNT_ID    <= 2'd0;
                    end
                end
                ST_BUSY: begin
                    if (!holder_req || preempt) begin
                        // Release and preemption both re-arbitrate in the same edge.
                        if (pick_found) begin
                            GNT       <= onehot(pick_idx);
                            GNT_VALID <= 1'b1;
                            GNT_ID    <= pick_idx;
                            hold_cnt  <= CNT_W'(1);
                            if (policy == ARB_RR) begin
                                rr_last <= pick_idx;
                            end
                        end else begin
                            state     <= ST_IDLE;
                            GNT       <= 4'd0;
                            GNT_VALID <= 1'b0;
                        end
                    end else if (hold_cnt < HOLD_MAX) begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    GNT       <= 4'd0;
                    GNT_VALID <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_arbiter.sv
// Directed bench for apb_arbiter: a per-cycle reference model of the grant rules
// plus literal expectations worked out by hand for each scenario.
module tb_apb_arbiter;

    localparam int MAX_HOLD = 8;
    localparam int CNT_W    = 4;

    logic       PCLK;
    logic       PRESETn;
    logic       APB_BYPASS;
    logic [3:0] APB_REQ;
    logic [2:0] APB_ARB_TYPE;
    logic [3:0] REQ;
    logic [3:0] GNT;
    logic       GNT_VALID;
    logic [1:0] GNT_ID;
    logic [1:0] dbg_state;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: who holds, for how long, and the last round-robin winner.
    bit         m_byp  = 1'b0;
    bit         m_busy = 1'b0;
    int         m_h    = 0;
    int         m_cnt  = 0;
    int         m_rr   = 3;
    logic [3:0] m_gnt  = 4'd0;
    int         m_id   = 0;

    apb_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
        .PCLK         (PCLK),
        .PRESETn      (PRESETn),
        .APB_BYPASS   (APB_BYPASS),
        .APB_REQ      (APB_REQ),
        .APB_ARB_TYPE (APB_ARB_TYPE),
        .REQ          (REQ),
        .GNT          (GNT),
        .GNT_VALID    (GNT_VALID),
        .GNT_ID       (GNT_ID),
        .dbg_state    (dbg_state)
    );

    // ---------------- clock ----------------
    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int lowest_set(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic int highest_set(input logic [3:0] v);
        for (int i = 3; i >= 0; i--) if (v[i]) return i;
        return -1;
    endfunction

    function automatic int next_after(input logic [3:0] v, input int last);
        for (int k = 1; k <= 4; k++) if (v[(last + k) % 4]) return (last + k) % 4;
        return -1;
    endfunction

    function automatic int choose(input logic [3:0] v, input int pol, input int last);
        if (pol == 1) return next_after(v, last);
        if (pol == 2) return highest_set(v);
        return lowest_set(v);
    endfunction

    task automatic give(input int p, input int pol);
        m_busy = 1'b1;
        m_h    = p;
        m_gnt  = 4'b0001 << p;
        m_id   = p;
        m_cnt  = 1;
        if (pol == 1) m_rr = p;
    endtask

    task automatic model_step();
        logic [3:0] e;
        logic [3:0] others;
        int pol;
        e   = REQ | APB_REQ;
        pol = (APB_ARB_TYPE == 3'd1) ? 1 : (APB_ARB_TYPE == 3'd2) ? 2 : 0;
        if (!PRESETn) begin
            m_byp = 1'b0; m_busy = 1'b0; m_gnt = 4'd0; m_id = 0; m_cnt = 0; m_rr = 3;
        end else if (APB_BYPASS) begin
            m_byp = 1'b1; m_busy = 1'b0; m_gnt = REQ; m_cnt = 0;
        end else if (m_byp) begin
            m_byp = 1'b0; m_gnt = 4'd0;
        end else if (!m_busy) begin
            if (e != 4'd0) give(choose(e, pol, m_rr), pol);
            else begin m_gnt = 4'd0; m_id = 0; end
        end else begin
            others = e & ~(4'b0001 << m_h);
            if (!e[m_h]) begin
                if (e != 4'd0) give(choose(e, pol, m_rr), pol);
                else begin m_busy = 1'b0; m_gnt = 4'd0; end
            end else if (pol == 1 && m_cnt == MAX_HOLD && others != 4'd0) begin
                give(choose(others, 1, m_rr), 1);
            end else if (m_cnt < MAX_HOLD) begin
                m_cnt++;
            end
        end
    endtask

    // Single compare process: model advances on each edge, outputs checked 2 time units later.
    always @(posedge PCLK) begin
        model_step();
        #2;
        check("gnt", GNT, m_gnt);
        check("gnt_valid", {3'b000, GNT_VALID}, {3'b000, |m_gnt});
        check("state", {2'b00, dbg_state}, m_byp ? 4'd2 : (m_busy ? 4'd1 : 4'd0));
        if (GNT_VALID && !m_byp) check("gnt_id", {2'b00, GNT_ID}, 4'(m_id));
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge PCLK);
    endtask

    task automatic expect_gnt(input string name, input logic [3:0] g);
        check(name, GNT, g);
        check({name, "_valid"}, {3'b000, GNT_VALID}, {3'b000, |g});
    endtask

    task automatic pulse_reset();
        PRESETn = 1'b0;
        tick();
        PRESETn = 1'b1;
    endtask

    logic [3:0] rr_seq [5];

    // ---------------- directed scenarios ----------------
    initial begin
        PRESETn = 1'b0; APB_BYPASS = 1'b0; APB_REQ = 4'd0; APB_ARB_TYPE = 3'd0; REQ = 4'd0;
        tick(); tick();
        expect_gnt("reset_gnt", 4'd0);
        check("reset_id", {2'b00, GNT_ID}, 4'd0);
        PRESETn = 1'b1;

        // Reset while a grant is held, then RR must start at client 0.
        REQ = 4'b0010; tick();
        expect_gnt("pre_reset_grant", 4'b0010);
        PRESETn = 1'b0; tick();
        expect_gnt("midgrant_reset", 4'd0);
        check("midgrant_reset_id", {2'b00, GNT_ID}, 4'd0);
        PRESETn = 1'b1; APB_ARB_TYPE = 3'd1; REQ = 4'b1111; tick();
        expect_gnt("rr_after_reset", 4'b0001);
        REQ = 4'd0; APB_ARB_TYPE = 3'd0; tick();
        expect_gnt("rr_release", 4'd0);

        // Fixed and reverse priority, release with no bubble.
        REQ = 4'b1010; tick();
        expect_gnt("fixed_1010", 4'b0010);
        REQ = 4'b1000; tick();
        expect_gnt("fixed_handover", 4'b1000);
        check("fixed_handover_id", {2'b00, GNT_ID}, 4'd3);
        REQ = 4'd0; tick();
        APB_ARB_TYPE = 3'd2; REQ = 4'b0011; tick();
        expect_gnt("rev_0011", 4'b0010);
        REQ = 4'd0; APB_ARB_TYPE = 3'd5; tick();
        REQ = 4'b0110; tick();
        expect_gnt("reserved_as_fixed", 4'b0010);
        REQ = 4'd0; APB_ARB_TYPE = 3'd0; tick();

        // Software-injected request.
        APB_REQ = 4'b0100; tick();
        expect_gnt("sw_inject", 4'b0100);
        check("sw_inject_id", {2'b00, GNT_ID}, 4'd2);
        APB_REQ = 4'd0; tick();
        expect_gnt("sw_clear", 4'd0);

        // Round-robin preemption every MAX_HOLD cycles.
        pulse_reset();
        rr_seq[0] = 4'b0001; rr_seq[1] = 4'b0010; rr_seq[2] = 4'b0100;
        rr_seq[3] = 4'b1000; rr_seq[4] = 4'b0001;
        APB_ARB_TYPE = 3'd1; REQ = 4'b1111;
        for (int s = 0; s < 5; s++) begin
            for (int c = 0; c < MAX_HOLD; c++) begin
                tick();
                expect_gnt($sformatf("rr_slot%0d_cyc%0d", s, c), rr_seq[s]);
            end
        end
        REQ = 4'd0; tick();

        // Fixed priority never preempts.
        APB_ARB_TYPE = 3'd0; REQ = 4'b1111;
        for (int c = 0; c < 20; c++) begin
            tick();
            expect_gnt($sformatf("fixed_hold_cyc%0d", c), 4'b0001);
        end
        REQ = 4'd0; tick();

        // Bypass: raw grant, then a single empty cycle on exit.
        APB_BYPASS = 1'b1; REQ = 4'b0101; tick();
        expect_gnt("bypass_raw", 4'b0101);
        APB_BYPASS = 1'b0; tick();
        expect_gnt("bypass_bubble", 4'd0);
        tick();
        expect_gnt("bypass_exit_grant", 4'b0001);
        REQ = 4'd0; tick();

        // Policy switch while client 2 holds: preempt only when its hold count saturates.
        pulse_reset();
        REQ = 4'b0100; tick();
        expect_gnt("switch_holder2", 4'b0100);
        REQ = 4'b0111; APB_ARB_TYPE = 3'd1;
        for (int c = 0; c < MAX_HOLD - 1; c++) begin
            tick();
            expect_gnt($sformatf("switch_hold_cyc%0d", c), 4'b0100);
        end
        tick();
        expect_gnt("switch_preempt", 4'b0001);
        REQ = 4'd0; APB_ARB_TYPE = 3'd0; tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
